// File: rtl/ahb_mem_pkg.sv
// Shared types, bus encodings and lane-mask helper for the AHB memory slave.
package ahb_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Registered address-phase attributes needed in the data phase
    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic [1:0] lane;
    } addr_phase_t;

    // Little-endian byte-lane mask for a transfer of the given size and low address bits
    function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (hsize)
            HSIZE_BYTE: be = 4'(4'b0001 << addr);
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word array with per-byte synchronous write and combinational read at one address.
module ahb_mem_array #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];

    // Contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB slave memory model: wait-state insertion, two-cycle ERROR responses, byte-lane writes.
module ahb_mem_slave
    import ahb_mem_pkg::*;
#(
    parameter int unsigned MEM_AW      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    localparam logic [32:0] MEM_BYTES = 33'(1) << (MEM_AW + 2);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    addr_phase_t         ap_q, ap_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;

    logic [31:0] offset;
    logic        sample;
    logic        xfer_err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        unused;

    assign unused = ^{HBURST, HPROT, HTRANS[0]};

    assign offset   = HADDR - BASE_ADDR;
    assign sample   = HSEL & HTRANS[1] & HREADY;
    assign xfer_err = ({1'b0, offset} >= MEM_BYTES)
                    | (HSIZE > HSIZE_WORD)
                    | ((HSIZE == HSIZE_HALF) & HADDR[0])
                    | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

    // Response outputs decode directly from the state register
    assign HREADY = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
    assign HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA = ((state_q == ST_LAST) && !ap_q.write) ? rdata : 32'h0000_0000;

    assign we = (state_q == ST_LAST) && ap_q.write;
    assign be = byte_en(ap_q.size, ap_q.lane);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ap_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ap_q    <= ap_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ap_d    = ap_q;
        idx_d   = idx_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, LAST and ERR2 all present HREADY high and may accept a new transfer
                if (sample) begin
                    ap_d.write = HWRITE;
                    ap_d.size  = HSIZE;
                    ap_d.lane  = HADDR[1:0];
                    idx_d      = offset[MEM_AW+1:2];
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (WS == 4'd0) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS - 4'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    ahb_mem_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk   (HCLK),
        .we    (we),
        .be    (be),
        .addr  (idx_q),
        .wdata (HWDATA),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: zero-wait instance (a) and three-wait-state instance (b) on a shared bus.
module tb_ahb_mem_slave;

    logic        clk;
    logic        hresetn;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b;
    logic [1:0]  resp_a, resp_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] SZ_B = 3'd0, SZ_W = 3'd2;

    ahb_mem_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_a (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HRDATA(rdata_a), .HREADY(ready_a), .HRESP(resp_a)
    );

    ahb_mem_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_b (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HRDATA(rdata_b), .HREADY(ready_b), .HRESP(resp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic [1:0] t, input logic w, input logic [2:0] s, input logic [31:0] a);
        htrans = t;
        hwrite = w;
        hsize  = s;
        haddr  = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        hresetn = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0;
        hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        #12;
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_resp_a",  32'(resp_a),  32'd0);
        chk("rst_rdata_a", rdata_a,      32'h0);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        tick();
        hresetn = 1'b1;
        tick();

        // Zero-wait write then back-to-back read of the same word
        hsel_a = 1'b1;
        ap(T_NSEQ, 1'b1, SZ_W, 32'h10);
        tick();
        chk("wr_dp_ready", 32'(ready_a), 32'd1);
        chk("wr_dp_resp",  32'(resp_a),  32'd0);
        hwdata = 32'hDEAD_BEEF;
        ap(T_NSEQ, 1'b0, SZ_W, 32'h10);
        tick();
        chk("rd_after_wr", rdata_a, 32'hDEAD_BEEF);
        ap(T_NSEQ, 1'b1, SZ_W, 32'h00);
        tick();
        chk("wr_rdata_zero", rdata_a, 32'h0);
        hwdata = 32'hCAFE_F00D;
        ap(T_NSEQ, 1'b1, SZ_W, 32'hFFC);
        tick();
        hwdata = 32'h0BAD_CAFE;
        ap(T_NSEQ, 1'b0, SZ_W, 32'hFFC);
        tick();
        chk("last_word_resp",  32'(resp_a), 32'd0);
        chk("last_word_rdata", rdata_a,     32'h0BAD_CAFE);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();
        chk("idle_rdata", rdata_a, 32'h0);

        // Byte writes land only in their lanes
        ap(T_NSEQ, 1'b1, SZ_W, 32'h20);
        tick();
        hwdata = 32'h0;
        ap(T_NSEQ, 1'b1, SZ_B, 32'h21);
        tick();
        hwdata = 32'h1122_AA44;
        ap(T_NSEQ, 1'b1, SZ_B, 32'h23);
        tick();
        hwdata = 32'h5566_7788;
        ap(T_NSEQ, 1'b0, SZ_W, 32'h20);
        tick();
        chk("byte_lanes", rdata_a, 32'h5500_AA00);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();

        // Out-of-range read: two-cycle ERROR
        ap(T_NSEQ, 1'b0, SZ_W, 32'h1000);
        tick();
        chk("oor_err1_ready", 32'(ready_a), 32'd0);
        chk("oor_err1_resp",  32'(resp_a),  32'd1);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();
        chk("oor_err2_ready", 32'(ready_a), 32'd1);
        chk("oor_err2_resp",  32'(resp_a),  32'd1);
        chk("oor_err2_rdata", rdata_a,      32'h0);
        tick();
        chk("oor_idle_resp",  32'(resp_a),  32'd0);

        // Misaligned word write, then read sampled during ERR2
        ap(T_NSEQ, 1'b1, SZ_W, 32'h02);
        tick();
        chk("mis_err1_ready", 32'(ready_a), 32'd0);
        chk("mis_err1_resp",  32'(resp_a),  32'd1);
        hwdata = 32'hFFFF_FFFF;
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();
        chk("mis_err2_ready", 32'(ready_a), 32'd1);
        chk("mis_err2_resp",  32'(resp_a),  32'd1);
        ap(T_NSEQ, 1'b0, SZ_W, 32'h00);
        tick();
        chk("mis_unchanged", rdata_a, 32'hCAFE_F00D);
        ap(T_NSEQ, 1'b0, 3'd3, 32'h10);
        tick();
        chk("badsize_resp", 32'(resp_a), 32'd1);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();
        tick();

        // INCR4 write burst with a BUSY after beat 2, then read back
        ap(T_NSEQ, 1'b1, SZ_W, 32'h40);
        tick();
        hwdata = 32'h1; ap(T_SEQ, 1'b1, SZ_W, 32'h44);
        tick();
        hwdata = 32'h2; ap(T_BUSY, 1'b1, SZ_W, 32'h48);
        tick();
        chk("busy_ready", 32'(ready_a), 32'd1);
        chk("busy_resp",  32'(resp_a),  32'd0);
        hwdata = 32'hBAD0_BAD0; ap(T_SEQ, 1'b1, SZ_W, 32'h48);
        tick();
        hwdata = 32'h3; ap(T_SEQ, 1'b1, SZ_W, 32'h4C);
        tick();
        hwdata = 32'h4; ap(T_NSEQ, 1'b0, SZ_W, 32'h40);
        tick();
        chk("burst_rd0", rdata_a, 32'h1);
        ap(T_SEQ, 1'b0, SZ_W, 32'h44);
        tick();
        chk("burst_rd1", rdata_a, 32'h2);
        ap(T_SEQ, 1'b0, SZ_W, 32'h48);
        tick();
        chk("burst_rd2", rdata_a, 32'h3);
        ap(T_SEQ, 1'b0, SZ_W, 32'h4C);
        tick();
        chk("burst_rd3", rdata_a, 32'h4);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();

        // Three wait states on instance b
        hsel_a = 1'b0;
        hsel_b = 1'b1;
        ap(T_NSEQ, 1'b1, SZ_W, 32'h80);
        tick();
        hwdata = 32'h1234_5678;
        ap(T_NSEQ, 1'b0, SZ_W, 32'h80);
        for (int i = 0; i < 3; i++) begin
            chk("ws_wr_wait_ready", 32'(ready_b), 32'd0);
            tick();
        end
        chk("ws_wr_last_ready", 32'(ready_b), 32'd1);
        chk("ws_wr_last_resp",  32'(resp_b),  32'd0);
        tick();
        ap(T_NSEQ, 1'b0, SZ_W, 32'h84);
        for (int i = 0; i < 3; i++) begin
            chk("ws_rd_wait_ready", 32'(ready_b), 32'd0);
            chk("ws_rd_wait_rdata", rdata_b,      32'h0);
            tick();
        end
        chk("ws_rd_last_ready", 32'(ready_b), 32'd1);
        chk("ws_rd_last_rdata", rdata_b,      32'h1234_5678);
        tick();
        chk("ws_next_sampled",  32'(ready_b), 32'd0);
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("ws_back_idle", 32'(ready_b), 32'd1);

        // Reset during the WAIT of a write aborts without committing
        ap(T_NSEQ, 1'b1, SZ_W, 32'h80);
        tick();
        hwdata = 32'hA5A5_A5A5;
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        tick();
        chk("pre_rst_ready", 32'(ready_b), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready_b), 32'd1);
        chk("async_rst_resp",  32'(resp_b),  32'd0);
        tick();
        tick();
        hresetn = 1'b1;
        tick();
        ap(T_NSEQ, 1'b0, SZ_W, 32'h80);
        tick();
        ap(T_IDLE, 1'b0, SZ_W, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_no_commit", rdata_b, 32'h1234_5678);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
